// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard controller for the 5-stage MIPS core.
//                Tracks the destination registers of the instructions in EX
//                and MEM, compares them against the sources of the instruction
//                in ID, and produces:
//                  - registered forwarding selects (fwd_a / fwd_b), valid in
//                    the consumer's EX cycle,
//                  - a one-cycle load-use stall (stall + bubble),
//                  - branch/jump flushes lasting FLUSH_CYCLES cycles,
//                  - saturating stall and flush event counters.
//
//  Ports
//    clk          in   system clock, rising edge
//    rst          in   asynchronous active-high reset
//    id_instr     in   [31:0] instruction currently in ID
//    id_regwr     in   RegWr decoded for id_instr
//    id_regdst    in   RegDst decoded for id_instr (1: rd, 0: rt)
//    id_memtoreg  in   MemToReg decoded for id_instr (instruction is a load)
//    redirect     in   taken branch / jump resolved in EX
//    stall        out  hold PC and IF/ID
//    bubble       out  load ID/EX with a NOP
//    flush        out  kill IF/ID contents
//    fwd_a        out  [1:0] operand A select (00 RF, 01 MEM ALU, 10 WB)
//    fwd_b        out  [1:0] operand B select, same encoding
//    stall_cnt    out  [CNT_W-1:0] load-use stall cycles, saturating
//    flush_cnt    out  [CNT_W-1:0] flush cycles, saturating
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1,   // 1..3
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_regwr,
    input  logic             id_regdst,
    input  logic             id_memtoreg,
    input  logic             redirect,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Number of flush cycles still to come after the redirect cycle itself.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t state;
    logic [1:0] flush_left;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic [4:0] id_dest;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_valid;
    logic       unused_instr_bits;

    assign id_op      = id_instr[31:26];
    assign id_rs      = id_instr[25:21];
    assign id_rt      = id_instr[20:16];
    assign id_rd      = id_instr[15:11];
    assign id_dest    = id_regdst ? id_rd : id_rt;
    assign id_rs_used = (id_op != OP_J);
    assign id_rt_used = (id_op == OP_RTYPE) || (id_op == OP_SW);
    // Writes to $0 are architecturally discarded, so they never occupy a slot.
    assign id_valid   = id_regwr && (id_dest != 5'd0);

    // Shift amount, funct and immediate play no part in hazard detection.
    assign unused_instr_bits = ^id_instr[10:0];

    // ------------------------------------------------------------------
    // Scoreboard: one entry per in-flight stage
    // ------------------------------------------------------------------
    logic       ex_valid;
    logic [4:0] ex_dest;
    logic       ex_load;
    logic       mem_valid;
    logic [4:0] mem_dest;

    // Forward select for one ID source; the nearer producer (EX) takes
    // precedence over the older one (MEM).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       used,
        input logic       e_valid,
        input logic [4:0] e_dest,
        input logic       m_valid,
        input logic [4:0] m_dest
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && (src != 5'd0)) begin
            if (e_valid && (e_dest == src)) begin
                sel = FWD_MEM;
            end else if (m_valid && (m_dest == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection and pipeline control (combinational)
    // ------------------------------------------------------------------
    logic rs_load_dep;
    logic rt_load_dep;
    logic load_use;
    logic flush_req;

    assign rs_load_dep = id_rs_used && (id_rs != 5'd0) && ex_valid && ex_load
                         && (ex_dest == id_rs);
    assign rt_load_dep = id_rt_used && (id_rt != 5'd0) && ex_valid && ex_load
                         && (ex_dest == id_rt);

    // Only raised from RUN: in LDSTALL the load has already moved to MEM.
    assign load_use  = (state == ST_RUN) && (rs_load_dep || rt_load_dep);
    assign flush_req = redirect || (state == ST_FLUSH);

    // A redirect kills the ID instruction, so a concurrent load-use hazard
    // is irrelevant and must not stall. Reset forces everything low at once.
    assign flush  = flush_req && !rst;
    assign stall  = load_use && !flush_req && !rst;
    assign bubble = stall || flush;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            flush_left <= 2'd0;
        end else if (redirect) begin
            // A new redirect (including one during FLUSH) restarts the window.
            flush_left <= FLUSH_LOAD;
            state      <= (FLUSH_LOAD == 2'd0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state)
                ST_RUN: begin
                    if (load_use) begin
                        state <= ST_LDSTALL;
                    end
                end
                ST_LDSTALL: begin
                    state <= ST_RUN;
                end
                ST_FLUSH: begin
                    // flush_left counts this cycle; leave when it is the last.
                    if (flush_left <= 2'd1) begin
                        flush_left <= 2'd0;
                        state      <= ST_RUN;
                    end else begin
                        flush_left <= flush_left - 2'd1;
                    end
                end
                default: begin
                    flush_left <= 2'd0;
                    state      <= ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_dest   <= 5'd0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dest  <= 5'd0;
        end else begin
            mem_valid <= ex_valid;
            mem_dest  <= ex_dest;
            ex_valid  <= id_valid && !bubble;
            ex_dest   <= id_dest;
            ex_load   <= id_memtoreg;
        end
    end

    // ------------------------------------------------------------------
    // Registered forwarding selects (consumer's EX cycle)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (bubble) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= fwd_sel(id_rs, id_rs_used, ex_valid, ex_dest,
                             mem_valid, mem_dest);
            fwd_b <= fwd_sel(id_rt, id_rt_used, ex_valid, ex_dest,
                             mem_valid, mem_dest);
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit. A pipeline-level model
//                tracks issued producers and flush/stall windows and checks
//                every output on each falling edge; directed instruction
//                sequences add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int FC      = 2;
    localparam int SAT_W   = 3;
    localparam int SAT_MAX = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_instr = 32'd0;
    logic        id_regwr = 1'b0;
    logic        id_regdst = 1'b0;
    logic        id_memtoreg = 1'b0;
    logic        redirect = 1'b0;

    logic        stall, bubble, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_bubble, s_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_unit #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_regwr(id_regwr),
        .id_regdst(id_regdst), .id_memtoreg(id_memtoreg), .redirect(redirect),
        .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy fed with the same stimulus to reach saturation.
    hazard_unit #(.FLUSH_CYCLES(FC), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_regwr(id_regwr),
        .id_regdst(id_regdst), .id_memtoreg(id_memtoreg), .redirect(redirect),
        .stall(s_stall), .bubble(s_bubble), .flush(s_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cap(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // ------------------------------------------------------------------
    // Model: history of what was issued into EX, window trackers, counts
    // ------------------------------------------------------------------
    typedef struct { bit v; int d; bit ld; } ent_t;
    ent_t h_ex, h_mem;
    bit   m_after_stall;     // previous cycle was a load-use stall
    int   m_flush_more;      // flush cycles still owed after the current one
    int   m_fa, m_fb;        // expected fwd values for the next cycle
    int   n_stall, n_flush;

    int   op, rs, rt, rd, dest;
    bit   rs_used, rt_used, e_ld, e_flush, e_stall, e_bub;

    function automatic int msel(input int src, input bit used, input ent_t a, input ent_t b);
        if (!used || src == 0) return 0;
        if (a.v && a.d == src) return 1;
        if (b.v && b.d == src) return 2;
        return 0;
    endfunction

    task automatic check_all(input int e_s, input int e_b, input int e_f,
                             input int e_fa, input int e_fb, input int ns, input int nf);
        chk("stall",      stall,      e_s);
        chk("bubble",     bubble,     e_b);
        chk("flush",      flush,      e_f);
        chk("fwd_a",      fwd_a,      e_fa);
        chk("fwd_b",      fwd_b,      e_fb);
        chk("stall_cnt",  stall_cnt,  cap(ns, 65535));
        chk("flush_cnt",  flush_cnt,  cap(nf, 65535));
        chk("sat_stall",  s_stall,    e_s);
        chk("sat_flush",  s_flush,    e_f);
        chk("sat_fwd_a",  s_fwd_a,    e_fa);
        chk("sat_scnt",   s_stall_cnt, cap(ns, SAT_MAX));
        chk("sat_fcnt",   s_flush_cnt, cap(nf, SAT_MAX));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_all(0, 0, 0, 0, 0, 0, 0);
            h_ex = '{0, 0, 0};
            h_mem = '{0, 0, 0};
            m_after_stall = 0;
            m_flush_more = 0;
            m_fa = 0;
            m_fb = 0;
            n_stall = 0;
            n_flush = 0;
        end else begin
            op = int'(id_instr[31:26]);
            rs = int'(id_instr[25:21]);
            rt = int'(id_instr[20:16]);
            rd = int'(id_instr[15:11]);
            dest = id_regdst ? rd : rt;
            rs_used = (op != 2);
            rt_used = (op == 0) || (op == 43);
            e_flush = redirect || (m_flush_more > 0);
            e_ld = !m_after_stall && (m_flush_more == 0) && h_ex.v && h_ex.ld &&
                   ((rs_used && rs == h_ex.d) || (rt_used && rt == h_ex.d));
            e_stall = e_ld && !e_flush;
            e_bub = e_stall || e_flush;

            check_all(e_stall, e_bub, e_flush, m_fa, m_fb, n_stall, n_flush);

            // advance to the next cycle
            n_stall += e_stall ? 1 : 0;
            n_flush += e_flush ? 1 : 0;
            m_fa = e_bub ? 0 : msel(rs, rs_used, h_ex, h_mem);
            m_fb = e_bub ? 0 : msel(rt, rt_used, h_ex, h_mem);
            h_mem = h_ex;
            h_ex.v  = !e_bub && id_regwr && (dest != 0);
            h_ex.d  = dest;
            h_ex.ld = id_memtoreg;
            m_after_stall = e_stall;
            if (redirect) m_flush_more = FC - 1;
            else if (m_flush_more > 0) m_flush_more--;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] rtype(input int s, input int t, input int d, input int fn);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int o, input int s, input int t, input int imm);
        return {6'(o), 5'(s), 5'(t), 16'(imm)};
    endfunction

    // Present one instruction in ID for one cycle; returns at mid-cycle.
    task automatic cyc(input logic [31:0] ins, input bit wr, input bit dst,
                       input bit m2r, input bit redir);
        @(posedge clk);
        #1;
        id_instr = ins;
        id_regwr = wr;
        id_regdst = dst;
        id_memtoreg = m2r;
        redirect = redir;
        @(negedge clk);
    endtask

    task automatic r_op(input int s, input int t, input int d, input int fn, input bit redir);
        cyc(rtype(s, t, d, fn), 1'b1, 1'b1, 1'b0, redir);
    endtask

    task automatic addi(input int t, input int s, input int imm, input bit redir);
        cyc(itype(8, s, t, imm), 1'b1, 1'b0, 1'b0, redir);
    endtask

    task automatic lw(input int t);
        cyc(itype(35, 0, t, 0), 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic nop(input bit redir);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, redir);
    endtask

    localparam int SUBU = 6'b100011;
    localparam int NOR  = 6'b100111;
    localparam int SLTU = 6'b101011;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("h_rst_stall", stall, 0);
        chk("h_rst_fwd_a", fwd_a, 0);
        chk("h_rst_scnt", stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back ALU dependency
        addi(1, 0, 5, 0);
        r_op(1, 1, 2, SUBU, 0);
        chk("h_b2b_stall", stall, 0);
        nop(0);
        chk("h_b2b_fwd_a", fwd_a, 1);
        chk("h_b2b_fwd_b", fwd_b, 1);

        // distance-2 dependency
        addi(3, 0, 1, 0);
        r_op(5, 5, 4, NOR, 0);
        r_op(3, 0, 6, SLTU, 0);
        nop(0);
        chk("h_d2_fwd_a", fwd_a, 2);
        chk("h_d2_fwd_b", fwd_b, 0);

        // load-use
        lw(7);
        r_op(7, 0, 8, SUBU, 0);
        chk("h_lu_stall", stall, 1);
        chk("h_lu_bubble", bubble, 1);
        r_op(7, 0, 8, SUBU, 0);
        chk("h_lu_stall2", stall, 0);
        nop(0);
        chk("h_lu_fwd_a", fwd_a, 2);
        chk("h_lu_scnt", stall_cnt, 1);

        // register 0 and unused sources
        addi(0, 0, 7, 0);
        r_op(0, 0, 9, SUBU, 0);
        nop(0);
        chk("h_r0_fwd_a", fwd_a, 0);
        chk("h_r0_fwd_b", fwd_b, 0);
        addi(2, 0, 3, 0);
        addi(1, 0, 1, 0);
        addi(2, 1, 1, 0);
        nop(0);
        chk("h_imm_fwd_a", fwd_a, 1);
        chk("h_imm_fwd_b", fwd_b, 0);

        // redirect, two-cycle flush, flushed producer never forwards
        addi(10, 0, 1, 1);
        chk("h_rd_flush", flush, 1);
        chk("h_rd_bubble", bubble, 1);
        r_op(10, 10, 11, SUBU, 0);
        chk("h_rd_flush2", flush, 1);
        r_op(10, 10, 12, SUBU, 0);
        chk("h_rd_flush3", flush, 0);
        chk("h_rd_fwd_a", fwd_a, 0);
        chk("h_rd_fcnt", flush_cnt, 2);
        nop(0);
        chk("h_rd_fwd_a2", fwd_a, 0);

        // redirect together with load-use
        lw(13);
        r_op(13, 0, 14, SUBU, 1);
        chk("h_sim_stall", stall, 0);
        chk("h_sim_flush", flush, 1);
        nop(0);
        nop(0);
        chk("h_sim_scnt", stall_cnt, 1);
        chk("h_sim_fcnt", flush_cnt, 4);

        // async reset in the middle of LDSTALL
        lw(15);
        r_op(15, 0, 16, SUBU, 0);
        chk("h_ar_stall", stall, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("h_ar_stall0", stall, 0);
        chk("h_ar_bubble0", bubble, 0);
        chk("h_ar_fwd_a0", fwd_a, 0);
        chk("h_ar_scnt0", stall_cnt, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("h_ar_nostall", stall, 0);
        nop(0);
        chk("h_ar_fwd_a", fwd_a, 0);

        // counter saturation on the narrow instance
        for (int i = 0; i < 8; i++) begin
            lw(17);
            r_op(17, 0, 18, SUBU, 0);
            r_op(17, 0, 18, SUBU, 0);
        end
        for (int i = 0; i < 10; i++) begin
            nop(1);
        end
        nop(0);
        nop(0);
        chk("h_sat_scnt", s_stall_cnt, 7);
        chk("h_sat_fcnt", s_flush_cnt, 7);
        chk("h_main_scnt", stall_cnt, 8);
        chk("h_main_fcnt", flush_cnt, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
